// File: rtl/fft_pkg.sv
// Shared types and helpers for the 8-point streaming FFT: complex sample
// formats, twiddle selection and output scaling/saturation.
package fft_pkg;

    localparam int N  = 8;
    localparam int DW = 17;
    localparam int TW = 181;
    // Internal component width: 20 bits of growth plus guard.
    localparam int IW = 24;
    localparam int SW = IW + 1;
    localparam int PW = IW + 11;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_w_t;

    typedef enum logic [1:0] {
        TW_ONE = 2'd0,
        TW_W81 = 2'd1,
        TW_NJ  = 2'd2,
        TW_W83 = 2'd3
    } tw_e;

    localparam logic signed [IW-1:0] SAT_MAX = 24'sd65535;
    localparam logic signed [IW-1:0] SAT_MIN = -24'sd65536;

    function automatic cplx_t unpack_word(input logic [2*DW-1:0] w);
        return cplx_t'(w);
    endfunction

    function automatic logic [2*DW-1:0] pack_word(input cplx_t c);
        return c;
    endfunction

    function automatic cplx_w_t widen(input cplx_t c);
        cplx_w_t r;
        r.re = IW'(c.re);
        r.im = IW'(c.im);
        return r;
    endfunction

    function automatic logic [2:0] bitrev3(input logic [2:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    // Multiply by 1/sqrt2 in Q0.8 with floor rounding.
    function automatic logic signed [IW-1:0] mul_tw(input logic signed [SW-1:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * PW'(TW);
        return IW'(p >>> 8);
    endfunction

    function automatic cplx_w_t twiddle(input cplx_w_t v, input tw_e sel);
        logic signed [SW-1:0] sum_s;
        logic signed [SW-1:0] dif_s;
        cplx_w_t r;
        sum_s = SW'(v.re) + SW'(v.im);
        dif_s = SW'(v.im) - SW'(v.re);
        case (sel)
            TW_ONE: r = v;
            TW_W81: begin
                r.re = mul_tw(sum_s);
                r.im = mul_tw(dif_s);
            end
            TW_NJ: begin
                r.re = v.im;
                r.im = -v.re;
            end
            TW_W83: begin
                r.re = mul_tw(dif_s);
                r.im = -mul_tw(sum_s);
            end
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic signed [DW-1:0] scale_sat(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] s;
        s = v >>> 3'd3;
        if (s > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (s < SAT_MIN) begin
            return DW'(SAT_MIN);
        end else begin
            return DW'(s);
        end
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 complex butterfly: sum = a + b, diff = twiddle(a - b).
module fft_butterfly
    import fft_pkg::*;
(
    input  logic [2*IW-1:0] a,
    input  logic [2*IW-1:0] b,
    input  logic [1:0]      tw_sel,
    output logic [2*IW-1:0] sum,
    output logic [2*IW-1:0] diff
);

    cplx_w_t a_s;
    cplx_w_t b_s;
    cplx_w_t sum_s;
    cplx_w_t dif_s;

    // Complex add/subtract followed by the selected twiddle on the difference.
    always_comb begin
        a_s      = cplx_w_t'(a);
        b_s      = cplx_w_t'(b);
        sum_s.re = a_s.re + b_s.re;
        sum_s.im = a_s.im + b_s.im;
        dif_s.re = a_s.re - b_s.re;
        dif_s.im = a_s.im - b_s.im;
        sum      = sum_s;
        diff     = twiddle(dif_s, tw_e'(tw_sel));
    end

endmodule

// File: rtl/fft_chip.sv
// Streaming 8-point radix-2 DIF FFT: buffers seven samples, transforms on the
// eighth, then plays the spectrum out in natural order while the next block loads.
module fft_chip
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [33:0] data_in,
    output logic [33:0] data_out
);

    logic [2:0] cnt_r;
    cplx_t      x_buf_r [0:6];
    cplx_t      bank_r  [1:7];
    cplx_w_t    st0_s   [0:7];
    cplx_w_t    st1_s   [0:7];
    cplx_w_t    st2_s   [0:7];
    cplx_w_t    st3_s   [0:7];
    cplx_t      fft_s   [0:7];

    // Stage-0 operands: buffered x[0..6] plus the live sample as x[7].
    always_comb begin
        for (int i = 0; i < 7; i++) begin
            st0_s[i] = widen(x_buf_r[i]);
        end
        st0_s[7] = widen(unpack_word(data_in));
    end

    for (genvar i = 0; i < 4; i++) begin : g_stage1
        fft_butterfly u_bf (
            .a      (st0_s[i]),
            .b      (st0_s[i+4]),
            .tw_sel (2'(i)),
            .sum    (st1_s[i]),
            .diff   (st1_s[i+4])
        );
    end

    for (genvar g = 0; g < 2; g++) begin : g_stage2
        for (genvar n = 0; n < 2; n++) begin : g_bf
            fft_butterfly u_bf (
                .a      (st1_s[4*g+n]),
                .b      (st1_s[4*g+n+2]),
                .tw_sel ((n == 0) ? TW_ONE : TW_NJ),
                .sum    (st2_s[4*g+n]),
                .diff   (st2_s[4*g+n+2])
            );
        end
    end

    // Final stage leaves X[k] at position bitrev(k).
    for (genvar j = 0; j < 4; j++) begin : g_stage3
        fft_butterfly u_bf (
            .a      (st2_s[2*j]),
            .b      (st2_s[2*j+1]),
            .tw_sel (TW_ONE),
            .sum    (st3_s[2*j]),
            .diff   (st3_s[2*j+1])
        );
    end

    // Reorder to natural frequency order, then scale by 1/8 and saturate.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            fft_s[k].re = scale_sat(st3_s[bitrev3(3'(k))].re);
            fft_s[k].im = scale_sat(st3_s[bitrev3(3'(k))].im);
        end
    end

    // Sample capture, block commit on x[7], and registered playout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= 3'd0;
            data_out <= 34'd0;
            for (int i = 0; i < 7; i++) begin
                x_buf_r[i] <= '0;
            end
            for (int i = 1; i < 8; i++) begin
                bank_r[i] <= '0;
            end
        end else begin
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r == 3'd7) begin
                for (int i = 1; i < 8; i++) begin
                    bank_r[i] <= fft_s[i];
                end
                data_out <= pack_word(fft_s[0]);
            end else begin
                x_buf_r[cnt_r] <= unpack_word(data_in);
                data_out       <= pack_word(bank_r[cnt_r + 3'd1]);
            end
        end
    end

endmodule

// File: tb/tb_fft_chip.sv
// Self-checking bench for fft_chip: directed spectra table, random blocks
// against a generic radix-2 DIF reference, and an asynchronous reset mid-block.
module tb_fft_chip;

    typedef int arr8_t [8];
    typedef struct {
        string name;
        arr8_t xr;
        arr8_t xi;
        arr8_t er;
        arr8_t ei;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [33:0] data_in = 34'd0;
    logic [33:0] data_out;

    int n_vec = 0;
    int n_err = 0;
    logic [33:0] exp_q [$];
    vec_t tbl [5];

    fft_chip dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] pk(input int r, input int i);
        logic [16:0] a;
        logic [16:0] b;
        a = 17'(r);
        b = 17'(i);
        return {a, b};
    endfunction

    function automatic longint cmul(input longint s);
        return (s * 181) >>> 8;
    endfunction

    function automatic int brev(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    // Generic in-place radix-2 DIF over spans 4,2,1 with W8 twiddle table.
    function automatic void model(input arr8_t xr, input arr8_t xi,
                                  output arr8_t er, output arr8_t ei);
        longint vr [8];
        longint vi [8];
        for (int n = 0; n < 8; n++) begin
            vr[n] = xr[n];
            vi[n] = xi[n];
        end
        for (int h = 4; h >= 1; h = h / 2) begin
            for (int base = 0; base < 8; base += 2 * h) begin
                for (int j = 0; j < h; j++) begin
                    longint dr, di, tr, ti;
                    dr = vr[base+j] - vr[base+j+h];
                    di = vi[base+j] - vi[base+j+h];
                    vr[base+j] = vr[base+j] + vr[base+j+h];
                    vi[base+j] = vi[base+j] + vi[base+j+h];
                    case (j * (4 / h))
                        1: begin tr = cmul(dr + di); ti = cmul(di - dr); end
                        2: begin tr = di; ti = -dr; end
                        3: begin tr = cmul(di - dr); ti = -cmul(dr + di); end
                        default: begin tr = dr; ti = di; end
                    endcase
                    vr[base+j+h] = tr;
                    vi[base+j+h] = ti;
                end
            end
        end
        for (int k = 0; k < 8; k++) begin
            longint r, i;
            r = vr[brev(k)] >>> 3;
            i = vi[brev(k)] >>> 3;
            if (r > 65535) r = 65535;
            if (r < -65536) r = -65536;
            if (i > 65535) i = 65535;
            if (i < -65536) i = -65536;
            er[k] = int'(r);
            ei[k] = int'(i);
        end
    endfunction

    task automatic check_out(input string tag);
        logic [33:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 34'd0;
        n_vec++;
        if (data_out !== e) begin
            n_err++;
            $display("FAIL %s: data_out=(%0d,%0d) expected=(%0d,%0d)", tag,
                     $signed(data_out[33:17]), $signed(data_out[16:0]),
                     $signed(e[33:17]), $signed(e[16:0]));
        end
    endtask

    // One block of 8 samples; its spectrum is queued on the x[7] edge.
    task automatic apply_block(input arr8_t xr, input arr8_t xi,
                               input arr8_t er, input arr8_t ei, input string tag);
        for (int n = 0; n < 8; n++) begin
            data_in = pk(xr[n], xi[n]);
            @(posedge clk);
            #1;
            if (n == 7) begin
                for (int k = 0; k < 8; k++) exp_q.push_back(pk(er[k], ei[k]));
            end
            check_out(tag);
        end
    endtask

    initial begin
        arr8_t rr, ri, mr, mi;
        int order [4];

        tbl[0].name = "impulse";
        tbl[0].xr = '{256, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].er = '{32, 32, 32, 32, 32, 32, 32, 32};
        tbl[0].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].name = "dc";
        tbl[1].xr = '{256, 256, 256, 256, 256, 256, 256, 256};
        tbl[1].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].er = '{256, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].name = "shifted_impulse";
        tbl[2].xr = '{0, 256, 0, 0, 0, 0, 0, 0};
        tbl[2].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].er = '{32, 22, 0, -23, -32, -23, 0, 22};
        tbl[2].ei = '{0, -23, -32, -23, 0, 22, 32, 22};
        tbl[3].name = "saturation";
        tbl[3].xr = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
        tbl[3].xi = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
        tbl[3].er = '{65535, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].ei = '{65535, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].name = "zeros";
        tbl[4].xr = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].xi = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].er = '{0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].ei = '{0, 0, 0, 0, 0, 0, 0, 0};

        #12;
        check_out("reset_state");
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            apply_block(tbl[t].xr, tbl[t].xi, tbl[t].er, tbl[t].ei, tbl[t].name);
        end

        order = '{0, 1, 4, 0};
        for (int t = 0; t < 4; t++) begin
            apply_block(tbl[order[t]].xr, tbl[order[t]].xi,
                        tbl[order[t]].er, tbl[order[t]].ei, "streaming");
        end

        for (int b = 0; b < 24; b++) begin
            for (int n = 0; n < 8; n++) begin
                if (b % 4 == 3) begin
                    rr[n] = ($urandom_range(0, 1) == 0) ? 65535 : -65536;
                    ri[n] = ($urandom_range(0, 1) == 0) ? 65535 : -65536;
                end else begin
                    rr[n] = int'($urandom_range(0, 131071)) - 65536;
                    ri[n] = int'($urandom_range(0, 131071)) - 65536;
                end
            end
            model(rr, ri, mr, mi);
            apply_block(rr, ri, mr, mi, "random");
        end

        // Partial block interrupted by reset while the previous spectrum plays out.
        apply_block(tbl[0].xr, tbl[0].xi, tbl[0].er, tbl[0].ei, "pre_reset_block");
        for (int n = 0; n < 5; n++) begin
            data_in = pk(100 * (n + 1), -50);
            @(posedge clk);
            #1;
            check_out("pre_reset_playout");
        end
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_out("reset_async");
        #2;
        rst_n = 1'b1;
        apply_block(tbl[2].xr, tbl[2].xi, tbl[2].er, tbl[2].ei, "post_reset");
        apply_block(tbl[4].xr, tbl[4].xi, tbl[4].er, tbl[4].ei, "post_reset_flush");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
